// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC-generation stage: reset address,
// controller state encoding and the layout of an in-flight tag entry.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // One in-flight tag is the request PC plus the epoch it was issued in
    localparam int TAG_W = 33;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetchState_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } tagEntry_t;

endpackage

// File: rtl/pc_tag_fifo.sv
// Generic synchronous FIFO with full/empty flags, wrap-around pointers and
// an occupancy count one bit wider than the pointers.
module pc_tag_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign doPush     = push_i & ~full_o;
    assign doPop      = pop_i & ~empty_o;
    assign headData_o = mem_q[rdPtr_q];

    // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the architectural fetch PC, issues in-order
// I-cache requests, pairs responses with their PC through a tag FIFO and
// discards responses from before a backend redirect using a 1-bit epoch.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] pred_pc,
    input  logic [31:0] pred_next_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_req_valid,
    input  logic        if_req_ready,
    output logic [31:0] if_req_pc,
    input  logic        if_resp_valid,
    output logic        if_resp_ready,
    input  logic [31:0] if_resp_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        resp_err
);

    fetchState_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        epoch_q, epoch_d;
    logic        outValid_q, outValid_d;
    logic [31:0] outPc_q, outPc_d;
    logic [31:0] outInst_q, outInst_d;
    logic        respErr_q, respErr_d;

    tagEntry_t   pushEntry;
    tagEntry_t   headEntry;
    logic        fifoFull;
    logic        fifoEmpty;

    logic        runState;
    logic        redirectTake;
    logic        reqValid;
    logic        reqFire;
    logic        headStale;
    logic        respReady;
    logic        respFire;
    logic        respPop;
    logic        liveLoad;
    logic        spurious;

    assign pushEntry = '{pc: pc_q, epoch: epoch_q};

    pc_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FQ_DEPTH)
    ) u_tagFifo (
        .clk        (clk),
        .rst        (resetn),
        .push_i     (reqFire),
        .pushData_i (pushEntry),
        .pop_i      (respPop),
        .headData_o (headEntry),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Handshake decode: a redirect suppresses the request and makes any same-cycle response stale
    always_comb begin
        runState     = (state_q == RUN);
        redirectTake = runState & redirect_valid;
        reqValid     = runState & ~fifoFull & ~redirect_valid;
        reqFire      = reqValid & if_req_ready;
        headStale    = redirectTake | (headEntry.epoch != epoch_q);
        respReady    = runState & (fifoEmpty | headStale | ~outValid_q | out_ready);
        respFire     = if_resp_valid & respReady;
        respPop      = respFire & ~fifoEmpty;
        liveLoad     = respPop & ~headStale;
        spurious     = respFire & fifoEmpty;
    end

    // Next fetch PC, epoch and boot sequencing
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirectTake) begin
                    pc_d    = {redirect_pc[31:2], 2'b00};
                    epoch_d = ~epoch_q;
                end else if (reqFire) begin
                    pc_d    = {pred_next_pc[31:2], 2'b00};
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Decode-side output register and sticky spurious-response flag
    always_comb begin
        outValid_d = outValid_q;
        outPc_d    = outPc_q;
        outInst_d  = outInst_q;
        respErr_d  = respErr_q | spurious;
        if (redirectTake) begin
            outValid_d = 1'b0;
        end else if (liveLoad) begin
            outValid_d = 1'b1;
            outPc_d    = headEntry.pc;
            outInst_d  = if_resp_inst;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Controller state: boot cycle, fetch PC and epoch
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            epoch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    // Output register toward decode
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            outValid_q <= 1'b0;
            outPc_q    <= '0;
            outInst_q  <= '0;
            respErr_q  <= 1'b0;
        end else begin
            outValid_q <= outValid_d;
            outPc_q    <= outPc_d;
            outInst_q  <= outInst_d;
            respErr_q  <= respErr_d;
        end
    end

    assign pred_pc       = pc_q;
    assign if_req_pc     = pc_q;
    assign if_req_valid  = reqValid;
    assign if_resp_ready = respReady;
    assign out_valid     = outValid_q;
    assign out_pc        = outPc_q;
    assign out_inst      = outInst_q;
    assign resp_err      = respErr_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed scenarios with fixed expected values
// followed by a randomized run against a transaction-level reference model.
module tb_fetch_pc_gen;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        resetn;
    logic [31:0] pred_pc;
    logic [31:0] pred_next_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_pc;
    logic        if_resp_valid;
    logic        if_resp_ready;
    logic [31:0] if_resp_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        resp_err;

    logic        predJump;
    logic [31:0] predTarget;

    int checks = 0;
    int errors = 0;

    // Reference model: in-flight requests as a queue of {pc, epoch}
    typedef struct packed {
        logic [31:0] pc;
        logic        epoch;
    } mEnt_t;

    mEnt_t       mQ[$];
    logic [31:0] mPc;
    logic        mEpoch;
    logic        mRun;
    logic        mOutValid;
    logic [31:0] mOutPc;
    logic [31:0] mOutInst;
    logic        mErr;

    fetch_pc_gen #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pred_pc        (pred_pc),
        .pred_next_pc   (pred_next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_req_pc      (if_req_pc),
        .if_resp_valid  (if_resp_valid),
        .if_resp_ready  (if_resp_ready),
        .if_resp_inst   (if_resp_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .resp_err       (resp_err)
    );

    // Predictor stub: sequential fetch unless a jump target is injected
    assign pred_next_pc = predJump ? predTarget : pred_pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_req_ready   = 1'b0;
        if_resp_valid  = 1'b0;
        if_resp_inst   = '0;
        out_ready      = 1'b1;
        predJump       = 1'b0;
        predTarget     = '0;
    endtask

    // Pulse reset and release it on a falling edge, leaving the DUT in its boot cycle
    task automatic resetDut();
        idleInputs();
        resetn = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        resetn = 1'b1;
        #12;
        checks++;
        if (if_req_valid !== 1'b0 || if_resp_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_pc !== 32'h0 || out_inst !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got req=%b rr=%b ov=%b pc=%h inst=%h err=%b expected all zero",
                     if_req_valid, if_resp_ready, out_valid, out_pc, out_inst, resp_err);
        end
        checks++;
        if (pred_pc !== RST_PC) begin
            errors++;
            $display("[TB] FAIL reset_pc got %h expected %h", pred_pc, RST_PC);
        end
        @(negedge clk);
        resetn       = 1'b0;
        if_req_ready = 1'b1;
        #1;
        checks++;
        if (if_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boot_no_req got %b expected 0", if_req_valid);
        end
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checks++;
            if (if_req_valid !== 1'b1 || if_req_pc !== RST_PC + 32'(4 * i)) begin
                errors++;
                $display("[TB] FAIL boot_seq%0d got valid=%b pc=%h expected valid=1 pc=%h",
                         i, if_req_valid, if_req_pc, RST_PC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_fifo_full();
        int n;
        resetDut();
        if_req_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (if_req_valid === 1'b1) n++;
            nextCycle();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("[TB] FAIL full_count got %0d expected 4", n);
        end
        #1;
        checks++;
        if (if_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_blocks got %b expected 0", if_req_valid);
        end
        if_resp_valid = 1'b1;
        if_resp_inst  = 32'h1234_5678;
        #1;
        checks++;
        if (if_resp_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_resp_ready got %b expected 1", if_resp_ready);
        end
        nextCycle();
        if_resp_valid = 1'b0;
        #1;
        checks++;
        if (if_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_reenable got %b expected 1", if_req_valid);
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL full_out got v=%b pc=%h inst=%h expected v=1 pc=%h inst=12345678",
                     out_valid, out_pc, out_inst, RST_PC);
        end
        if_req_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        resetDut();
        if_req_ready = 1'b1;
        nextCycle();
        repeat (3) nextCycle();
        if_req_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1003;
        #1;
        checks++;
        if (if_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_no_req got %b expected 0", if_req_valid);
        end
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (if_req_valid !== 1'b1 || if_req_pc !== 32'h8000_1000) begin
            errors++;
            $display("[TB] FAIL redir_target got valid=%b pc=%h expected valid=1 pc=80001000",
                     if_req_valid, if_req_pc);
        end
        if_req_ready = 1'b1;
        nextCycle();
        if_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_resp_valid = 1'b1;
            if_resp_inst  = 32'h1110_0000 + 32'(i);
            #1;
            checks++;
            if (if_resp_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL redir_stale_ready%0d got %b expected 1", i, if_resp_ready);
            end
            nextCycle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL redir_stale_drop%0d got out_valid=%b expected 0", i, out_valid);
            end
        end
        if_resp_inst = 32'h0000_CAFE;
        nextCycle();
        if_resp_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_1000 || out_inst !== 32'h0000_CAFE) begin
            errors++;
            $display("[TB] FAIL redir_first_new got v=%b pc=%h inst=%h expected v=1 pc=80001000 inst=0000cafe",
                     out_valid, out_pc, out_inst);
        end
        nextCycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL redir_out_clear got %b expected 0", out_valid);
        end
    endtask

    task automatic test_decode_stall();
        resetDut();
        if_req_ready = 1'b1;
        nextCycle();
        repeat (2) nextCycle();
        if_req_ready  = 1'b0;
        out_ready     = 1'b0;
        if_resp_valid = 1'b1;
        if_resp_inst  = 32'hAAAA_0001;
        nextCycle();
        if_resp_inst  = 32'hBBBB_0002;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (if_resp_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_resp_ready%0d got %b expected 0", i, if_resp_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_pc !== RST_PC || out_inst !== 32'hAAAA_0001) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d got v=%b pc=%h inst=%h expected v=1 pc=%h inst=aaaa0001",
                         i, out_valid, out_pc, out_inst, RST_PC);
            end
            nextCycle();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (if_resp_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release got %b expected 1", if_resp_ready);
        end
        nextCycle();
        if_resp_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RST_PC + 32'd4 || out_inst !== 32'hBBBB_0002) begin
            errors++;
            $display("[TB] FAIL stall_second got v=%b pc=%h inst=%h expected v=1 pc=%h inst=bbbb0002",
                     out_valid, out_pc, out_inst, RST_PC + 32'd4);
        end
        nextCycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_drain got %b expected 0", out_valid);
        end
    endtask

    task automatic test_redirect_same_cycle();
        resetDut();
        if_req_ready = 1'b1;
        nextCycle();
        repeat (2) nextCycle();
        if_req_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        if_resp_valid  = 1'b1;
        if_resp_inst   = 32'h0000_DEAD;
        #1;
        checks++;
        if (if_resp_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_ready got %b expected 1", if_resp_ready);
        end
        nextCycle();
        redirect_valid = 1'b0;
        if_resp_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_drop got out_valid=%b expected 0", out_valid);
        end
        if_req_ready = 1'b1;
        nextCycle();
        if_req_ready  = 1'b0;
        if_resp_valid = 1'b1;
        if_resp_inst  = 32'h0000_0BAD;
        nextCycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_stale_drop got out_valid=%b expected 0", out_valid);
        end
        if_resp_inst = 32'h0000_600D;
        nextCycle();
        if_resp_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0000_2000 || out_inst !== 32'h0000_600D) begin
            errors++;
            $display("[TB] FAIL same_new got v=%b pc=%h inst=%h expected v=1 pc=00002000 inst=0000600d",
                     out_valid, out_pc, out_inst);
        end
        if_req_ready = 1'b1;
        #2;
        resetn = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || if_req_valid !== 1'b0 ||
            if_resp_ready !== 1'b0 || resp_err !== 1'b0 || pred_pc !== RST_PC) begin
            errors++;
            $display("[TB] FAIL midreset got v=%b pc=%h inst=%h req=%b rr=%b err=%b ppc=%h expected zeros and ppc=%h",
                     out_valid, out_pc, out_inst, if_req_valid, if_resp_ready, resp_err, pred_pc, RST_PC);
        end
    endtask

    task automatic test_spurious();
        resetDut();
        nextCycle();
        #1;
        checks++;
        if (resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spur_pre got %b expected 0", resp_err);
        end
        if_resp_valid = 1'b1;
        if_resp_inst  = 32'h5555_5555;
        #1;
        checks++;
        if (if_resp_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spur_ready got %b expected 1", if_resp_ready);
        end
        nextCycle();
        if_resp_valid = 1'b0;
        checks++;
        if (resp_err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spur_flag got err=%b ov=%b expected err=1 ov=0", resp_err, out_valid);
        end
        if_req_ready = 1'b1;
        nextCycle();
        if_req_ready  = 1'b0;
        if_resp_valid = 1'b1;
        if_resp_inst  = 32'h7777_0000;
        nextCycle();
        if_resp_valid = 1'b0;
        checks++;
        if (resp_err !== 1'b1 || out_valid !== 1'b1 || out_pc !== RST_PC) begin
            errors++;
            $display("[TB] FAIL spur_sticky got err=%b ov=%b pc=%h expected err=1 ov=1 pc=%h",
                     resp_err, out_valid, out_pc, RST_PC);
        end
        #2;
        resetn = 1'b1;
        #1;
        checks++;
        if (resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spur_reset got %b expected 0", resp_err);
        end
    endtask

    // Advance the reference model by one clock using the inputs currently driven
    task automatic modelAdvance();
        logic  redir;
        logic  reqFire;
        logic  live;
        logic  respReady;
        logic  loaded;
        mEnt_t head;
        redir     = mRun && redirect_valid;
        reqFire   = mRun && !redirect_valid && (mQ.size() < DEPTH) && if_req_ready;
        live      = (mQ.size() != 0) && !redir && (mQ[0].epoch == mEpoch);
        respReady = mRun && (!live || !mOutValid || out_ready);
        loaded    = 1'b0;
        if (if_resp_valid && respReady) begin
            if (mQ.size() == 0) begin
                mErr = 1'b1;
            end else begin
                head = mQ.pop_front();
                if (live) begin
                    loaded   = 1'b1;
                    mOutPc   = head.pc;
                    mOutInst = if_resp_inst;
                end
            end
        end
        if (redir)          mOutValid = 1'b0;
        else if (loaded)    mOutValid = 1'b1;
        else if (out_ready) mOutValid = 1'b0;
        if (reqFire) mQ.push_back('{pc: mPc, epoch: mEpoch});
        if (redir) begin
            mPc    = redirect_pc & ~32'd3;
            mEpoch = ~mEpoch;
        end else if (reqFire) begin
            mPc = (predJump ? predTarget : mPc + 32'd4) & ~32'd3;
        end
        mRun = 1'b1;
    endtask

    task automatic test_random();
        logic live;
        logic expReq;
        logic expRr;
        resetDut();
        mQ.delete();
        mPc       = RST_PC;
        mEpoch    = 1'b0;
        mRun      = 1'b0;
        mOutValid = 1'b0;
        mOutPc    = '0;
        mOutInst  = '0;
        mErr      = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if_req_ready   = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            predJump       = ($urandom_range(0, 3) == 0);
            predTarget     = $urandom;
            out_ready      = ($urandom_range(0, 3) != 0);
            if (mQ.size() != 0) if_resp_valid = ($urandom_range(0, 2) != 0);
            else                if_resp_valid = ($urandom_range(0, 63) == 0);
            if_resp_inst   = $urandom;
            #1;
            live   = (mQ.size() != 0) && !(mRun && redirect_valid) && (mQ[0].epoch == mEpoch);
            expReq = mRun && !redirect_valid && (mQ.size() < DEPTH);
            expRr  = mRun && (!live || !mOutValid || out_ready);
            checks++;
            if (if_req_valid !== expReq || pred_pc !== mPc || if_req_pc !== mPc) begin
                errors++;
                $display("[TB] FAIL rnd_req cyc=%0d got v=%b pc=%h ppc=%h expected v=%b pc=%h",
                         cyc, if_req_valid, if_req_pc, pred_pc, expReq, mPc);
            end
            checks++;
            if (if_resp_ready !== expRr) begin
                errors++;
                $display("[TB] FAIL rnd_resp_ready cyc=%0d got %b expected %b", cyc, if_resp_ready, expRr);
            end
            checks++;
            if (out_valid !== mOutValid || out_pc !== mOutPc || out_inst !== mOutInst || resp_err !== mErr) begin
                errors++;
                $display("[TB] FAIL rnd_out cyc=%0d got v=%b pc=%h inst=%h err=%b expected v=%b pc=%h inst=%h err=%b",
                         cyc, out_valid, out_pc, out_inst, resp_err, mOutValid, mOutPc, mOutInst, mErr);
            end
            modelAdvance();
            nextCycle();
        end
        idleInputs();
    endtask

    initial begin
        test_reset();
        test_fifo_full();
        test_redirect_flush();
        test_decode_stall();
        test_redirect_same_cycle();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- PC-generation and fetch-tracking stage immediately upstream of the branch predictor.
- Holds the architectural fetch PC and drives it to the predictor as `pred_pc`. Advances to the predictor's combinational `pred_next_pc` on each accepted I-cache request.
- Tracks in-flight requests in an in-order tag FIFO, so responses are paired with their PC.
- Backend redirects flush in-flight work through a 1-bit epoch.

Parameters:
- RESET_PC, 32'hBFC0_0000: fetch address loaded on reset.
- FQ_DEPTH, 4: maximum outstanding I-cache requests (power of 2, ≥2).

Ports:
- clk  in  1  sole clock, rising edge
- resetn  in  1  one clock; reset is asynchronous and active-high (asserted = 1 despite the name)
- pred_pc  out  32  current fetch PC to branch predictor
- pred_next_pc  in  32  predictor's next PC for pred_pc (combinational)
- redirect_valid  in  1  backend mispredict/exception redirect
- redirect_pc  in  32  redirect target
- if_req_valid  out  1  I-cache request valid
- if_req_ready  in  1  I-cache accepts request
- if_req_pc  out  32  request address (= pred_pc)
- if_resp_valid  in  1  I-cache response, strictly in request order
- if_resp_ready  out  1  stage can take response
- if_resp_inst  in  32  fetched instruction
- out_valid  out  1  instruction to decode valid
- out_ready  in  1  decode accepts
- out_pc  out  32  PC of out_inst
- out_inst  out  32  instruction
- resp_err  out  1  sticky: response arrived with FIFO empty

Behaviour:
- State:
  - pc_q: 32 bits.
  - epoch_q: 1 bit.
  - FSM {BOOT, RUN}.
  - Tag FIFO: FQ_DEPTH entries of {pc[31:0], epoch}, with wrap-around pointers and a count of log2(FQ_DEPTH)+1 bits.
  - Output register: {out_valid, out_pc, out_inst}.
- Reset (async, mid-operation included):
  - pc_q=RESET_PC, epoch_q=0, FSM=BOOT.
  - FIFO empty; out_valid=0, out_pc=0, out_inst=0, resp_err=0.
  - if_req_valid=0, if_resp_ready=0.
- BOOT: one cycle with no request, then RUN unconditionally. BOOT also ignores redirects.
- pred_pc = if_req_pc = pc_q, combinationally.
- if_req_valid = RUN & !fifo_full & !redirect_valid.
- Request fire (valid & ready):
  - pc_q <= {pred_next_pc[31:2], 2'b00}.
  - Push {pc_q, epoch_q}.
- No fire: pc_q holds. Predictor output is ignored that cycle.
- Redirect (RUN, redirect_valid=1):
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - epoch_q toggles.
  - No request issued that cycle.
  - out_valid cleared the same edge.
  - FIFO entries are not drained; they become stale.
- Consecutive redirects: each one reloads pc_q and toggles the epoch again. The last one wins.
- Response handling (head = FIFO head):
  - Stale head (head.epoch != epoch_q, evaluated after a same-cycle redirect toggle): if_resp_ready=1. Response popped and discarded.
  - Live head: if_resp_ready = !out_valid | out_ready. On fire, pop and load out register {1, head.pc, if_resp_inst}.
  - Same cycle as a redirect: the response counts as stale and is discarded.
  - FIFO empty: if_resp_ready=1. An arriving response sets resp_err and is dropped; there is no pop.
- Output: out_valid clears on out_ready & !new load. Back-to-back load with out_ready=1 sustains 1 instr/cycle.
- Push and pop in the same cycle: count unchanged. Full FIFO blocks requests only.
- Latency: I-cache response to out_valid is 1 cycle. Redirect to first request is 1 cycle.
- All PC arithmetic is 32-bit. Bits [1:0] are always 0 on pred_pc, if_req_pc and out_pc.

Decomposition:
- fetch_pkg holds:
  - RESET_PC default
  - FSM state encodings BOOT/RUN
  - tag-entry width constant (33)
- One sub-module, pc_tag_fifo: generic synchronous FIFO with full/empty/count, async active-high reset.
- fetch_pc_gen instantiates pc_tag_fifo and holds the FSM, epoch and output register.

Test Plan:
- Reset, then check the boot cycle.
  - Stimulus: release reset; if_req_ready=1; predictor stub returns pc+4.
  - Required response: cycle 0 if_req_valid=0. Cycle 1 request at 0xBFC00000. Then 0xBFC00004 and 0xBFC00008 on consecutive cycles.
- FIFO full backpressure.
  - Stimulus: if_req_ready=1 with no responses for 6 cycles.
  - Required response: exactly 4 requests, then if_req_valid=0. One response re-enables a request the next cycle.
- Redirect flush.
  - Stimulus: 3 requests outstanding, then redirect_valid with redirect_pc=0x80001003.
  - Required response: next request at 0x80001000. The 3 old responses are accepted and discarded with out_valid never set. The first new response appears with out_pc=0x80001000.
- Decode stall.
  - Stimulus: out_ready=0 while a live response arrives, then a second response arrives.
  - Required response: the first is held in out_*. if_resp_ready=0 for the second until out_ready=1, then streams in order.
- Redirect with a same-cycle response.
  - Required response: that response is dropped. Also assert reset mid-stream: all outputs return to reset values asynchronously.
- Spurious response.
  - Stimulus: if_resp_valid=1 with the FIFO empty.
  - Required response: resp_err=1 and it stays 1 until reset; out_valid=0.
